// File: rtl/program_loader.sv
// program_loader: streams a program image into the processor's unified memory, then releases the CPU.
// Optional macro LOADER_CHECKSUM_EN turns the in_last word into a checksum trailer.
module program_loader #(
  parameter int MEM_DEPTH = 64,
  parameter int CNT_W     = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  input  logic             reload,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wd,
  output logic             cpu_reset,
  output logic             load_done,
  output logic             load_error,
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic [1:0] {LOAD, RELEASE, RUN, ERR} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MEM_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MEM_DEPTH);

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wd_q, mem_wd_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic             load_done_q, load_done_d;
  logic             load_error_q, load_error_d;
  logic             xfer;
  logic             write_word;
  logic             restart;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]      sum_q, sum_d;
`endif

  // in_ready is a flop, so it is guaranteed low during reset and only rises on the first edge after it.
  assign xfer    = in_valid && in_ready_q;
  assign restart = reload && ((state_q == RUN) || (state_q == ERR));

  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wd_d     = mem_wd_q;
    write_word   = xfer;
`ifdef LOADER_CHECKSUM_EN
    sum_d        = sum_q;
    if (in_last) write_word = 1'b0;
`endif

    case (state_q)
      LOAD: begin
        if (xfer) begin
          if (in_last) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = (in_data == sum_q) ? RELEASE : ERR;
`else
            state_d = RELEASE;
`endif
          end else if (word_count_q == LAST_IDX) begin
            state_d = ERR;
          end
        end
      end
      RELEASE: state_d = RUN;
      RUN, ERR: if (reload) state_d = LOAD;
      default:  state_d = LOAD;
    endcase

    if (write_word) begin
      mem_we_d   = 1'b1;
      mem_addr_d = 32'(word_count_q) << 2;
      mem_wd_d   = in_data;
      if (word_count_q != FULL_CNT) word_count_d = word_count_q + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
      sum_d      = sum_q + in_data;
`endif
    end

    if (restart) begin
      word_count_d = '0;
`ifdef LOADER_CHECKSUM_EN
      sum_d        = '0;
`endif
    end

    // Release status trails the RUN state by one edge so the CPU leaves reset two edges after the last word.
    in_ready_d   = (state_d == LOAD);
    cpu_reset_d  = !((state_q == RUN) && !reload);
    load_done_d  = (state_q == RUN) && !reload;
    load_error_d = (state_d == ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= LOAD;
      in_ready_q   <= 1'b0;
      word_count_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wd_q     <= '0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      word_count_q <= word_count_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wd_q     <= mem_wd_d;
      cpu_reset_q  <= cpu_reset_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wd     = mem_wd_q;
  assign cpu_reset  = cpu_reset_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a 64-word and a 4-word instance share one clock,
// with a high-level load model predicting writes, final state and word count.
module tb_program_loader;

   logic        clk;
   logic        reset;
   logic        sel;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_last;
   logic        reload;

   logic        aReady, aWe, aCpuReset, aDone, aError;
   logic [31:0] aAddr, aWd;
   logic [6:0]  aCount;
   logic        bReady, bWe, bCpuReset, bDone, bError;
   logic [31:0] bAddr, bWd;
   logic [2:0]  bCount;

   logic        curReady, curWe, curCpuReset, curDone, curError;
   logic [31:0] curAddr, curWd;
   logic [6:0]  curCount;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] stimWords[$];
   logic        stimLast[$];
   logic [63:0] expWrites[$];
   logic [63:0] actWrites[$];
   int          expAccepted;
   int          expOutcome;
   int          expCount;

   program_loader #(.MEM_DEPTH(64), .CNT_W(7)) dutA (
      .clk(clk), .reset(reset), .in_valid(in_valid && !sel), .in_ready(aReady),
      .in_data(in_data), .in_last(in_last), .reload(reload && !sel),
      .mem_we(aWe), .mem_addr(aAddr), .mem_wd(aWd), .cpu_reset(aCpuReset),
      .load_done(aDone), .load_error(aError), .word_count(aCount));

   program_loader #(.MEM_DEPTH(4), .CNT_W(3)) dutB (
      .clk(clk), .reset(reset), .in_valid(in_valid && sel), .in_ready(bReady),
      .in_data(in_data), .in_last(in_last), .reload(reload && sel),
      .mem_we(bWe), .mem_addr(bAddr), .mem_wd(bWd), .cpu_reset(bCpuReset),
      .load_done(bDone), .load_error(bError), .word_count(bCount));

   // The selected instance is the one being driven and observed.
   always_comb begin
      curReady    = sel ? bReady    : aReady;
      curWe       = sel ? bWe       : aWe;
      curCpuReset = sel ? bCpuReset : aCpuReset;
      curDone     = sel ? bDone     : aDone;
      curError    = sel ? bError    : aError;
      curAddr     = sel ? bAddr     : aAddr;
      curWd       = sel ? bWd       : aWd;
      curCount    = sel ? 7'(bCount) : aCount;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every write strobe seen mid-cycle is logged for comparison against the model.
   always @(negedge clk) begin
      if (curWe) actWrites.push_back({curAddr, curWd});
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Reference model: walk the image word by word and decide what the loader must do with it.
   function automatic void modelLoad(input int depth);
      int          cnt;
      logic [31:0] sum;
      cnt = 0;
      sum = '0;
      expWrites.delete();
      expAccepted = 0;
      expOutcome  = 2;
      for (int i = 0; i < stimWords.size(); i++) begin
         expAccepted++;
`ifdef LOADER_CHECKSUM_EN
         if (stimLast[i]) begin
            expOutcome = (stimWords[i] == sum) ? 0 : 1;
            break;
         end
`endif
         expWrites.push_back({32'(4 * cnt), stimWords[i]});
         sum = sum + stimWords[i];
         cnt++;
         if (stimLast[i]) begin
            expOutcome = 0;
            break;
         end
         if (cnt == depth) begin
            expOutcome = 1;
            break;
         end
      end
      expCount = cnt;
   endfunction

   task automatic applyStimulus(input logic [31:0] w, input logic l, input int gapMode);
      int gaps;
      int waited;
      gaps = (gapMode == 1) ? 1 : (gapMode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (gaps) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_data  = $urandom;
         in_last  = 1'($urandom_range(0, 1));
         reload   = (gapMode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = w;
      in_last  = l;
      reload   = 1'b0;
      waited   = 0;
      while (!curReady && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("accept_ready", 32'(curReady), 32'd1);
      @(posedge clk);
   endtask

   task automatic doReload();
      @(negedge clk);
      in_valid = 1'b0;
      reload   = 1'b1;
      @(negedge clk);
      reload   = 1'b0;
      checkOutput("reload_done", 32'(curDone), 32'd0);
      checkOutput("reload_error", 32'(curError), 32'd0);
      checkOutput("reload_cpu_reset", 32'(curCpuReset), 32'd1);
      checkOutput("reload_count", 32'(curCount), 32'd0);
      checkOutput("reload_ready", 32'(curReady), 32'd1);
   endtask

   task automatic runScenario(input int depth, input int gapMode);
      modelLoad(depth);
      actWrites.delete();
      for (int i = 0; i < expAccepted; i++) applyStimulus(stimWords[i], stimLast[i], gapMode);
      @(negedge clk);
      in_valid = 1'b0;
      if (expOutcome == 0) begin
         checkOutput("release_ready", 32'(curReady), 32'd0);
         checkOutput("release_cpu_reset0", 32'(curCpuReset), 32'd1);
         @(negedge clk);
         checkOutput("release_cpu_reset1", 32'(curCpuReset), 32'd1);
         checkOutput("release_done1", 32'(curDone), 32'd0);
         @(negedge clk);
         checkOutput("run_cpu_reset", 32'(curCpuReset), 32'd0);
         checkOutput("run_done", 32'(curDone), 32'd1);
         checkOutput("run_error", 32'(curError), 32'd0);
         checkOutput("run_ready", 32'(curReady), 32'd0);
         checkOutput("run_count", 32'(curCount), 32'(expCount));
      end else if (expOutcome == 1) begin
         checkOutput("err_error", 32'(curError), 32'd1);
         checkOutput("err_cpu_reset", 32'(curCpuReset), 32'd1);
         checkOutput("err_done", 32'(curDone), 32'd0);
         checkOutput("err_count", 32'(curCount), 32'(expCount));
         if (stimWords.size() > expAccepted) begin
            in_valid = 1'b1;
            in_data  = stimWords[expAccepted];
            in_last  = stimLast[expAccepted];
            repeat (3) begin
               checkOutput("err_ready", 32'(curReady), 32'd0);
               @(negedge clk);
            end
            in_valid = 1'b0;
         end
         @(negedge clk);
         checkOutput("err_no_write", 32'(curWe), 32'd0);
      end
      checkOutput("write_total", 32'(actWrites.size()), 32'(expWrites.size()));
      for (int i = 0; i < expWrites.size() && i < actWrites.size(); i++) begin
         checkOutput("write_addr", actWrites[i][63:32], expWrites[i][63:32]);
         checkOutput("write_data", actWrites[i][31:0], expWrites[i][31:0]);
      end
   endtask

   task automatic loadDirectedImage();
      stimWords = '{32'h20080005, 32'h20090003, 32'h01095020, 32'hAC0A0000, 32'h8C0B0000, 32'h11080000};
      stimLast  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   endtask

   task automatic loadRandomImage(input int maxLen);
      int          len;
      logic [31:0] sum;
      len = int'($urandom_range(1, maxLen));
      sum = '0;
      stimWords.delete();
      stimLast.delete();
      for (int i = 0; i < len; i++) begin
         stimWords.push_back($urandom);
         stimLast.push_back(i == len - 1);
         if (i == len - 1 && $urandom_range(0, 1) == 1) stimWords[i] = sum;
         sum = sum + stimWords[i];
      end
   endtask

   initial begin
      sel      = 1'b0;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      reload   = 1'b0;
      #1;
      checkOutput("rst_cpu_reset", 32'(curCpuReset), 32'd1);
      checkOutput("rst_ready", 32'(curReady), 32'd0);
      checkOutput("rst_we", 32'(curWe), 32'd0);
      checkOutput("rst_count", 32'(curCount), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      checkOutput("ready_at_release", 32'(curReady), 32'd0);
      @(negedge clk);
      checkOutput("ready_after_edge", 32'(curReady), 32'd1);

      $display("[TB] directed image, back-to-back");
      loadDirectedImage();
      runScenario(64, 0);

      $display("[TB] directed image, valid toggling");
      doReload();
      runScenario(64, 1);

      $display("[TB] checksum images");
      doReload();
      stimWords = '{32'd5, 32'd3, 32'd9};
      stimLast  = '{1'b0, 1'b0, 1'b1};
      runScenario(64, 0);
      doReload();
      stimWords = '{32'd5, 32'd3, 32'd8};
      runScenario(64, 0);
      doReload();
      stimWords = '{32'd0};
      stimLast  = '{1'b1};
      runScenario(64, 0);

      $display("[TB] reload then single word");
      doReload();
      stimWords = '{32'h0000000A};
      stimLast  = '{1'b1};
      runScenario(64, 0);

      $display("[TB] random images with gaps");
      for (int r = 0; r < 3; r++) begin
         doReload();
         loadRandomImage(12);
         runScenario(64, 2);
      end

      $display("[TB] reset mid-load");
      doReload();
      loadDirectedImage();
      for (int i = 0; i < 3; i++) applyStimulus(stimWords[i], stimLast[i], 0);
      #2;
      reset    = 1'b1;
      in_valid = 1'b0;
      #1;
      checkOutput("midrst_cpu_reset", 32'(curCpuReset), 32'd1);
      checkOutput("midrst_we", 32'(curWe), 32'd0);
      checkOutput("midrst_addr", curAddr, 32'd0);
      checkOutput("midrst_wd", curWd, 32'd0);
      checkOutput("midrst_count", 32'(curCount), 32'd0);
      checkOutput("midrst_done", 32'(curDone), 32'd0);
      checkOutput("midrst_error", 32'(curError), 32'd0);
      checkOutput("midrst_ready", 32'(curReady), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      runScenario(64, 0);

      $display("[TB] four-word memory");
      @(negedge clk);
      sel = 1'b1;
      stimWords.delete();
      stimLast.delete();
      for (int i = 0; i < 5; i++) begin
         stimWords.push_back($urandom);
         stimLast.push_back(1'b0);
      end
      runScenario(4, 0);
      doReload();
      stimLast = '{1'b0, 1'b0, 1'b0, 1'b1};
      stimWords.delete();
      for (int i = 0; i < 4; i++) stimWords.push_back($urandom);
      runScenario(4, 0);
      for (int r = 0; r < 2; r++) begin
         doReload();
         loadRandomImage(6);
         runScenario(4, 2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
